excp_commit_ctrl: RTL
=====================

EXCP_COMMIT_CTRL -- requirements
Module: excp_commit_ctrl

Interface
REQ-001 SHALL have parameter INT_ECODE, default 6'h00, the ecode reported for a taken interrupt.
REQ-002 SHALL have parameter DRAIN_MAX, default 16'd1023, the DRAIN cycle limit before drain_timeout sets.
REQ-003 SHALL have ports clk (in, 1, the single clock) and reset (in, 1, synchronous active-high reset).
REQ-004 SHALL have ports wb_valid (in, 1, WB holds an instruction) and wb_excp (in, 1, that instruction carries an exception).
REQ-005 SHALL have ports wb_ecode_in (in, 6), wb_esubcode_in (in, 9), wb_pc_in (in, 32) and wb_ertn (in, 1, instruction is ERTN).
REQ-006 SHALL have ports has_int (in, 1, pending enabled interrupt from CSR unit) and mem_busy (in, 1, data-memory transaction outstanding).
REQ-007 SHALL have ports ex_entry (in, 32) and er_entry (in, 32), the CSR EENTRY and ERA values.
REQ-008 SHALL have output wb_stall (1), which blocks WB commit.
REQ-009 SHALL have outputs csr_wb_ex (1), csr_ecode (6), csr_esubcode (9) and csr_era_pc (32), which drive the CSR exception-write port.
REQ-010 SHALL have output csr_ertn_flush (1), which drives the CSR ERTN restore.
REQ-011 SHALL have output flush (1), which kills IF..MEM.
REQ-012 SHALL have ports redirect_valid (out, 1), redirect_pc (out, 32) and redirect_ready (in, 1), a valid/ready handshake to Pre-IF.
REQ-013 SHALL have output drain_timeout (1), a sticky error flag.

Function
REQ-014 SHALL implement the FSM states IDLE, DRAIN, COMMIT and REDIRECT.
REQ-015 An event is detected in IDLE when wb_valid & (has_int | wb_excp | wb_ertn).
REQ-016 Event priority SHALL be interrupt > exception > ERTN.
- Interrupt: ecode = INT_ECODE, esubcode = 0.
- Exception: wb_ecode_in / wb_esubcode_in.
REQ-017 On a detected event the block SHALL latch the type, ecode, esubcode and wb_pc_in in the same cycle.
- Next state is DRAIN if mem_busy=1, else COMMIT.
REQ-018 wb_stall SHALL be combinational 1 in the detect cycle and registered 1 in DRAIN, COMMIT and REDIRECT; the event instruction never commits.
REQ-019 DRAIN SHALL hold until mem_busy=0, then go to COMMIT.
- drain_cnt (16b) increments each DRAIN cycle and saturates.
- drain_timeout sets when drain_cnt reaches DRAIN_MAX; it is cleared only by reset.
- The block stays in DRAIN while mem_busy=1 regardless of the timeout.
REQ-020 COMMIT SHALL last exactly 1 cycle and pulse flush=1.
- Interrupt/exception: csr_wb_ex=1 with latched code fields; csr_era_pc = latched pc.
- ERTN: csr_ertn_flush=1.
- csr_wb_ex and csr_ertn_flush are never both 1.
REQ-021 REDIRECT SHALL assert redirect_valid=1.
- redirect_pc = ex_entry for interrupt/exception, er_entry for ERTN.
- redirect_pc is sampled on the first REDIRECT cycle and held stable while redirect_ready=0.
REQ-022 On redirect_valid & redirect_ready the block SHALL return to IDLE; wb_stall drops in the following cycle.
REQ-023 Minimum event latency SHALL be detect -> COMMIT +1 cycle -> REDIRECT +2 -> IDLE +3 (mem_busy=0, redirect_ready=1).
REQ-024 wb_valid, has_int, wb_excp and wb_ertn SHALL be ignored outside IDLE; no event is queued.
REQ-025 The back-to-back case SHALL be handled as follows.
- A new event may be detected in the first IDLE cycle after REDIRECT.
- has_int may still be 1 there; it is taken again only if wb_valid=1.
REQ-026 Outside their states, csr_wb_ex, csr_ertn_flush, flush and redirect_valid SHALL be 0, and the code/pc outputs SHALL hold their latched values.

Reset
REQ-027 Reset SHALL force state IDLE, all outputs 0 (including wb_stall, drain_timeout and redirect_pc) and drain_cnt=0.
REQ-028 Reset asserted in any state SHALL abort the sequence with no CSR pulse; outputs are 0 on the next cycle.

Verification
REQ-029 Exception path:
- Stimulus: wb_valid=1, wb_excp=1, ecode=6'h0B, pc=0x1C000100, mem_busy=0, ex_entry=0x1C008000, redirect_ready=1.
- Required: csr_wb_ex pulse at +1 with ecode 0x0B and era_pc 0x1C000100; redirect_pc 0x1C008000 at +2; IDLE at +3.
REQ-030 ERTN path:
- Stimulus: wb_ertn=1, er_entry=0x1C000200.
- Required: csr_ertn_flush=1 for exactly 1 cycle, csr_wb_ex=0, redirect_pc=0x1C000200.
REQ-031 Priority:
- Stimulus: has_int=1, wb_excp=1 and wb_ertn=1 together.
- Required: csr_wb_ex with ecode=INT_ECODE and esubcode=0; no csr_ertn_flush.
REQ-032 Drain and backpressure:
- Stimulus: mem_busy=1 for 5 cycles, redirect_ready=0 for 3 cycles.
- Required: COMMIT occurs 1 cycle after mem_busy falls; redirect_pc stays stable for 3 cycles; wb_stall=1 throughout.
REQ-033 Timeout:
- Stimulus: DRAIN_MAX=8, mem_busy held at 1.
- Required: drain_timeout=1 after 8 DRAIN cycles and stays 1 after mem_busy falls.
REQ-034 Reset mid-operation:
- Stimulus: reset asserted during REDIRECT.
- Required: all outputs 0 the next cycle; a later event runs the full sequence.

Source files
------------

// File: rtl/excp_commit_ctrl.sv
// Exception / interrupt / ERTN commit controller.
// Catches an event at WB, stalls WB, waits for outstanding data-memory
// traffic to drain, pulses the CSR exception or ERTN write together with a
// pipeline flush, then hands the new fetch PC to Pre-IF over valid/ready.
module excp_commit_ctrl #(
    parameter logic [5:0]  INT_ECODE = 6'h00,
    parameter logic [15:0] DRAIN_MAX = 16'd1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_excp,
    input  logic [5:0]  wb_ecode_in,
    input  logic [8:0]  wb_esubcode_in,
    input  logic [31:0] wb_pc_in,
    input  logic        wb_ertn,
    input  logic        has_int,
    input  logic        mem_busy,
    input  logic [31:0] ex_entry,
    input  logic [31:0] er_entry,
    output logic        wb_stall,
    output logic        csr_wb_ex,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic [31:0] csr_era_pc,
    output logic        csr_ertn_flush,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        drain_timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        ev_detect;
    logic        ev_is_ertn;
    logic        stall_q;
    logic [15:0] drain_cnt;
    logic [15:0] drain_cnt_inc;

    // Event detection, next-state selection and state-decoded outputs
    always_comb begin
        ev_detect      = 1'b0;
        state_nxt      = state;
        drain_cnt_inc  = (drain_cnt == '1) ? drain_cnt : drain_cnt + 16'd1;
        if (state == IDLE && !reset)
            ev_detect = wb_valid & (has_int | wb_excp | wb_ertn);
        case (state)
            IDLE:     if (ev_detect) state_nxt = mem_busy ? DRAIN : COMMIT;
            DRAIN:    if (!mem_busy) state_nxt = COMMIT;
            COMMIT:   state_nxt = REDIRECT;
            REDIRECT: if (redirect_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        // detect cycle stalls combinationally; later cycles use the register
        wb_stall       = stall_q | ev_detect;
        flush          = (state == COMMIT);
        csr_wb_ex      = (state == COMMIT) & ~ev_is_ertn;
        csr_ertn_flush = (state == COMMIT) & ev_is_ertn;
        redirect_valid = (state == REDIRECT);
    end

    // State register and registered stall for all non-IDLE states
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            stall_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            stall_q <= (state_nxt != IDLE);
        end
    end

    // Capture event type, cause codes and PC in the detect cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_is_ertn   <= 1'b0;
            csr_ecode    <= '0;
            csr_esubcode <= '0;
            csr_era_pc   <= '0;
        end else if (ev_detect) begin
            // interrupt > exception > ERTN; ERTN leaves the cause fields alone
            ev_is_ertn <= ~has_int & ~wb_excp;
            csr_era_pc <= wb_pc_in;
            if (has_int) begin
                csr_ecode    <= INT_ECODE;
                csr_esubcode <= '0;
            end else if (wb_excp) begin
                csr_ecode    <= wb_ecode_in;
                csr_esubcode <= wb_esubcode_in;
            end
        end
    end

    // Redirect target: loaded at the COMMIT->REDIRECT edge so it is already
    // valid in the first REDIRECT cycle and held through backpressure
    always_ff @(posedge clk) begin
        if (reset)
            redirect_pc <= '0;
        else if (state == COMMIT)
            redirect_pc <= ev_is_ertn ? er_entry : ex_entry;
    end

    // Saturating per-event drain counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt     <= '0;
            drain_timeout <= 1'b0;
        end else if (ev_detect) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt_inc;
            if (drain_cnt_inc >= DRAIN_MAX)
                drain_timeout <= 1'b1;
        end
    end

endmodule
